uart_rx_autobaud: RTL and testbench

- Automatic baud-rate configurator for the UART receive path.
- Armed by software, it times a 0x55 sync character on RX_IN and computes the oversampling clock divide ratio.
- Gates the RX datapath (FSM, sampler, deserializer) off while measuring and enables it once locked.
- Sits between the serial pin and the RX prescaler/divider configuration.

---
 rtl/uart_rx_autobaud_if.sv | 31 +++
 rtl/uart_rx_autobaud.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_autobaud.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_autobaud_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_autobaud_if
// Purpose  : Serial line, control pulses and configuration outputs of the
//            UART RX auto-baud configurator.
// Revision : 1.0
// ============================================================================
interface uart_rx_autobaud_if #(
    parameter int CNT_W = 16
);
    logic             rx_in;
    logic             autobaud_start;
    logic             autobaud_abort;
    logic [CNT_W-1:0] div_ratio;
    logic             cfg_valid;
    logic             locked;
    logic             rx_enable;
    logic             busy;
    logic             baud_error;

    modport master (
        output rx_in, autobaud_start, autobaud_abort,
        input  div_ratio, cfg_valid, locked, rx_enable, busy, baud_error
    );

    modport slave (
        input  rx_in, autobaud_start, autobaud_abort,
        output div_ratio, cfg_valid, locked, rx_enable, busy, baud_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_autobaud.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_autobaud
// Purpose  : Times a 0x55 sync character on the RX pin and derives the
//            oversampling divide ratio; gates the RX datapath until locked.
// Revision : 1.0
// ============================================================================
module uart_rx_autobaud #(
    parameter int CNT_W    = 16,
    parameter int OVS_LOG2 = 3,
    parameter int MIN_LOW  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    uart_rx_autobaud_if.slave bus
);
    localparam int                 c_TOT_W   = CNT_W + 3;
    localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_MIN_LOW = CNT_W'(MIN_LOW);
    localparam logic [c_TOT_W-1:0] c_ROUND   = c_TOT_W'(2 ** (2 + OVS_LOG2));

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_WAIT_START = 3'd1;
    localparam logic [2:0] c_ST_CHECK_LOW  = 3'd2;
    localparam logic [2:0] c_ST_MEASURE    = 3'd3;
    localparam logic [2:0] c_ST_WAIT_STOP  = 3'd4;
    localparam logic [2:0] c_ST_DONE       = 3'd5;
    localparam logic [2:0] c_ST_ERROR      = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_sync;
    logic               r_prev;
    logic               w_line;
    logic               w_fall;
    logic               w_rise;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_ref;
    logic [c_TOT_W-1:0] r_total;
    logic [1:0]         r_idx;
    logic               r_stop_seen;
    logic [CNT_W-1:0]   w_ival;
    logic [CNT_W-1:0]   w_diff;
    logic [CNT_W-1:0]   w_ratio;
    logic               w_cnt_sat;
    logic               w_tol_bad;
    logic               w_abort;
    logic               w_busy;
    logic               w_load;
    logic               w_err;
    logic [CNT_W-1:0]   r_div_ratio;
    logic               r_cfg_valid;
    logic               r_locked;
    logic               r_baud_error;

    // Synchronizer and edge detector idle high so reset never produces an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], bus.rx_in};
            r_prev <= r_sync[1];
        end
    end

    assign w_line    = r_sync[1];
    assign w_fall    = r_prev & ~w_line;
    assign w_rise    = ~r_prev & w_line;
    assign w_cnt_sat = (r_cnt == c_CNT_MAX);
    assign w_ival    = r_cnt + c_ONE;
    assign w_diff    = (w_ival >= r_ref) ? (w_ival - r_ref) : (r_ref - w_ival);
    assign w_tol_bad = (w_diff > (r_ref >> 3));
    assign w_ratio   = CNT_W'((r_total + c_ROUND) >> (3 + OVS_LOG2));
    assign w_abort   = bus.autobaud_abort && (r_state != c_ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.autobaud_start) w_state_nxt = c_ST_WAIT_START;
                end
                c_ST_WAIT_START: begin
                    if (w_fall) w_state_nxt = c_ST_CHECK_LOW;
                end
                c_ST_CHECK_LOW: begin
                    if (w_rise && (r_cnt < c_MIN_LOW)) w_state_nxt = c_ST_WAIT_START;
                    else if (w_cnt_sat)                w_state_nxt = c_ST_ERROR;
                    else if (r_cnt >= c_MIN_LOW)       w_state_nxt = c_ST_MEASURE;
                end
                c_ST_MEASURE: begin
                    if (w_cnt_sat) begin
                        w_state_nxt = c_ST_ERROR;
                    end else if (w_fall) begin
                        if ((r_idx != 2'd0) && w_tol_bad) w_state_nxt = c_ST_ERROR;
                        else if (r_idx == 2'd3)           w_state_nxt = c_ST_WAIT_STOP;
                    end
                end
                c_ST_WAIT_STOP: begin
                    // Stop edge must arrive within one reference interval, then
                    // the line is checked half a bit later
                    if (w_cnt_sat)                            w_state_nxt = c_ST_ERROR;
                    else if (!r_stop_seen && (r_cnt > r_ref)) w_state_nxt = c_ST_ERROR;
                    else if (r_stop_seen && (r_cnt == (r_ref >> 2)))
                        w_state_nxt = w_line ? c_ST_DONE : c_ST_ERROR;
                end
                c_ST_DONE: begin
                    w_state_nxt = (w_ratio == '0) ? c_ST_ERROR : c_ST_IDLE;
                end
                c_ST_ERROR: begin
                    w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state != c_ST_IDLE);
        w_load = 1'b0;
        w_err  = 1'b0;
        if (!w_abort) begin
            w_load = (r_state == c_ST_DONE) && (w_ratio != '0);
            w_err  = (r_state == c_ST_ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_ref       <= '0;
            r_total     <= '0;
            r_idx       <= 2'd0;
            r_stop_seen <= 1'b0;
        end else begin
            if (!w_cnt_sat) r_cnt <= w_ival;
            case (r_state)
                c_ST_WAIT_START: begin
                    if (w_fall) begin
                        r_cnt       <= '0;
                        r_total     <= '0;
                        r_idx       <= 2'd0;
                        r_stop_seen <= 1'b0;
                    end
                end
                c_ST_MEASURE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_total <= r_total + c_TOT_W'(w_ival);
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd0) r_ref <= w_ival;
                    end
                end
                c_ST_WAIT_STOP: begin
                    if (w_rise && !r_stop_seen) begin
                        r_cnt       <= '0;
                        r_stop_seen <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_ratio  <= '0;
            r_cfg_valid  <= 1'b0;
            r_locked     <= 1'b0;
            r_baud_error <= 1'b0;
        end else begin
            r_cfg_valid  <= w_load;
            r_baud_error <= w_err;
            if (w_load) begin
                r_div_ratio <= w_ratio;
                r_locked    <= 1'b1;
            end else if ((r_state == c_ST_IDLE) && bus.autobaud_start) begin
                r_locked    <= 1'b0;
            end
        end
    end

    assign bus.div_ratio  = r_div_ratio;
    assign bus.cfg_valid  = r_cfg_valid;
    assign bus.locked     = r_locked;
    assign bus.rx_enable  = r_locked;
    assign bus.busy       = w_busy;
    assign bus.baud_error = r_baud_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_autobaud.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_autobaud
// Purpose  : Randomized and directed scoreboard bench for two auto-baud
//            instances (x8 / 16-bit and x16 / 8-bit counters).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_autobaud;
    logic clk;
    logic rst_n;
    logic rx    [2];
    logic start [2];
    logic abort [2];
    int   checks;
    int   errors;
    int   last_ratio [2];
    int   exp_q0 [$];
    int   exp_q1 [$];

    uart_rx_autobaud_if #(.CNT_W(16)) bus0 ();
    uart_rx_autobaud_if #(.CNT_W(8))  bus1 ();

    assign bus0.rx_in          = rx[0];
    assign bus0.autobaud_start = start[0];
    assign bus0.autobaud_abort = abort[0];
    assign bus1.rx_in          = rx[1];
    assign bus1.autobaud_start = start[1];
    assign bus1.autobaud_abort = abort[1];

    uart_rx_autobaud #(.CNT_W(16), .OVS_LOG2(3), .MIN_LOW(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    uart_rx_autobaud #(.CNT_W(8), .OVS_LOG2(4), .MIN_LOW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Expected outcome from the frame's edge timing: -1 for a rejected
    // measurement, otherwise the rounded divide ratio.
    function automatic int model(input logic [7:0] data, input int dur [10], input int ovs, input int cntw);
        logic [9:0] lv;
        int t, prev, ref_iv, total, r;
        int falls [$];
        int iv [$];
        lv   = {1'b1, data, 1'b0};
        t    = 0;
        prev = 1;
        for (int b = 0; b < 10; b++) begin
            if (prev == 1 && lv[b] == 1'b0) falls.push_back(t);
            prev = int'(lv[b]);
            t += dur[b];
        end
        for (int k = 1; k < falls.size(); k++) iv.push_back(falls[k] - falls[k-1]);
        if (iv.size() == 0) return -1;
        ref_iv = iv[0];
        for (int k = 0; k < iv.size() && k < 4; k++) begin
            if (iv[k] >= (1 << cntw)) return -1;
            if (k > 0 && ((iv[k] > ref_iv) ? iv[k] - ref_iv : ref_iv - iv[k]) > (ref_iv >> 3)) return -1;
        end
        if (iv.size() < 4) return -1;
        if (dur[8] - 1 > ref_iv) return -1;
        total = iv[0] + iv[1] + iv[2] + iv[3];
        r = ((total + (1 << (2 + ovs))) >> (3 + ovs)) & ((1 << cntw) - 1);
        return (r == 0) ? -1 : r;
    endfunction

    task automatic mon(input int idx, input logic cv, input logic be, input logic [31:0] ratio,
                       input logic lk, input logic re, input logic bs);
        int e;
        int sz;
        if (cv !== 1'b1 && be !== 1'b1) return;
        sz = (idx == 0) ? exp_q0.size() : exp_q1.size();
        chk("event_expected", idx, (sz > 0) ? 1 : 0, 1);
        if (sz == 0) return;
        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("baud_error_kind", idx, {31'd0, be}, (e < 0) ? 1 : 0);
        chk("cfg_valid_kind", idx, {31'd0, cv}, (e < 0) ? 0 : 1);
        chk("div_ratio", idx, ratio, (e < 0) ? last_ratio[idx] : e);
        chk("locked", idx, {31'd0, lk}, (e < 0) ? 0 : 1);
        chk("rx_enable", idx, {31'd0, re}, (e < 0) ? 0 : 1);
        chk("busy_after_event", idx, {31'd0, bs}, 0);
        if (e >= 0) last_ratio[idx] = e;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon(0, bus0.cfg_valid, bus0.baud_error, 32'(bus0.div_ratio), bus0.locked, bus0.rx_enable, bus0.busy);
            mon(1, bus1.cfg_valid, bus1.baud_error, 32'(bus1.div_ratio), bus1.locked, bus1.rx_enable, bus1.busy);
        end
    end

    function automatic logic busy_of(input int idx);
        return (idx == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic locked_of(input int idx);
        return (idx == 0) ? bus0.locked : bus1.locked;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int idx);
        start[idx] = 1'b1;
        tick(1);
        start[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n;
        n = 0;
        while (busy_of(idx) && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_within_budget", idx, {31'd0, busy_of(idx)}, 0);
    endtask

    task automatic drive_frame(input int idx, input logic [7:0] data, input int dur [10]);
        logic [9:0] lv;
        lv = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx[idx] = lv[b];
            tick(dur[b]);
        end
        rx[idx] = 1'b1;
    endtask

    task automatic run_frame(input int idx, input logic [7:0] data, input int dur [10], input int glitch);
        int e;
        e = model(data, dur, (idx == 0) ? 3 : 4, (idx == 0) ? 16 : 8);
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
        pulse_start(idx);
        chk("locked_cleared_by_start", idx, {31'd0, locked_of(idx)}, 0);
        tick(3);
        if (glitch > 0) begin
            rx[idx] = 1'b0;
            tick(glitch);
            rx[idx] = 1'b1;
            tick(10);
        end
        drive_frame(idx, data, dur);
        wait_idle(idx, 4000);
        tick(4);
    endtask

    task automatic uniform(input int p, output int d [10]);
        for (int b = 0; b < 10; b++) d[b] = p;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d [10];
        int p;
        int j;
        int idx;
        checks = 0;
        errors = 0;
        last_ratio[0] = 0;
        last_ratio[1] = 0;
        for (int i = 0; i < 2; i++) begin
            rx[i] = 1'b1;
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        rst_n = 1'b0;
        tick(3);
        chk("reset_outputs", 0, 32'({bus0.div_ratio, bus0.cfg_valid, bus0.locked, bus0.rx_enable, bus0.busy, bus0.baud_error}), 0);
        chk("reset_outputs", 1, 32'({bus1.div_ratio, bus1.cfg_valid, bus1.locked, bus1.rx_enable, bus1.busy, bus1.baud_error}), 0);
        rst_n = 1'b1;
        tick(3);

        uniform(32, d);
        run_frame(0, 8'h55, d, 0);
        uniform(100, d);
        run_frame(1, 8'h55, d, 0);
        uniform(104, d);
        run_frame(1, 8'h55, d, 0);
        uniform(32, d);
        run_frame(0, 8'h55, d, 2);
        run_frame(0, 8'h53, d, 0);

        // Line held low on the 8-bit instance until its counter saturates
        exp_q1.push_back(-1);
        pulse_start(1);
        rx[1] = 1'b0;
        tick(5);
        wait_idle(1, 1000);
        rx[1] = 1'b1;
        tick(10);

        // Abort in the middle of the interval measurement
        pulse_start(0);
        tick(3);
        rx[0] = 1'b0; tick(32);
        rx[0] = 1'b1; tick(32);
        rx[0] = 1'b0; tick(10);
        chk("busy_in_measure", 0, {31'd0, bus0.busy}, 1);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        chk("busy_after_abort", 0, {31'd0, bus0.busy}, 0);
        chk("locked_after_abort", 0, {31'd0, bus0.locked}, 0);
        rx[0] = 1'b1;
        tick(150);

        for (int i = 0; i < 24; i++) begin
            idx = i % 2;
            p = (idx == 0) ? int'($urandom_range(8, 60)) : int'($urandom_range(40, 100));
            j = p / 6;
            for (int b = 0; b < 10; b++) d[b] = p - j + int'($urandom_range(0, 2 * j));
            run_frame(idx, 8'h55, d, 0);
        end

        // Asynchronous reset while measuring
        pulse_start(0);
        tick(3);
        rx[0] = 1'b0; tick(32);
        rx[0] = 1'b1; tick(32);
        rx[0] = 1'b0; tick(10);
        chk("busy_before_reset", 0, {31'd0, bus0.busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 0, 32'({bus0.div_ratio, bus0.cfg_valid, bus0.locked, bus0.rx_enable, bus0.busy, bus0.baud_error}), 0);
        chk("async_reset_outputs", 1, 32'({bus1.div_ratio, bus1.cfg_valid, bus1.locked, bus1.rx_enable, bus1.busy, bus1.baud_error}), 0);
        last_ratio[0] = 0;
        last_ratio[1] = 0;
        rx[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        uniform(32, d);
        run_frame(0, 8'h55, d, 0);

        tick(10);
        chk("pending_events", 0, exp_q0.size(), 0);
        chk("pending_events", 1, exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
